// File: rtl/freq_div_pkg.sv
// Shared phase encoding and step function for the divide-by-1.5 clock generator.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package freq_div_pkg;

    localparam int DIV_CYCLES = 3;

    typedef enum logic [1:0] {
        PH_A    = 2'd0,
        PH_B    = 2'd1,
        PH_IDLE = 2'd2
    } phase_t;

    // Phase sequence wraps after DIV_CYCLES steps and never reaches encoding 3.
    function automatic phase_t next_phase(input phase_t ph);
        if (int'(ph) >= DIV_CYCLES - 1) begin
            return PH_A;
        end
        return phase_t'(ph + 2'd1);
    endfunction

endpackage

// File: rtl/freq_div_1p5_edge.sv
// Single-bit flag register with synchronous reset, clocked on the selected edge of clk.
// Latency: one edge of the selected polarity.
// Backpressure: none; captures d on every selected edge.
module freq_div_edge_flag
    import freq_div_pkg::*;
#(
    parameter bit NEG_EDGE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    generate
        if (NEG_EDGE) begin : g_neg
            always_ff @(negedge clk) begin
                if (rst) begin
                    q <= 1'b0;
                end else begin
                    q <= d;
                end
            end
        end else begin : g_pos
            always_ff @(posedge clk) begin
                if (rst) begin
                    q <= 1'b0;
                end else begin
                    q <= d;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/freq_div_1p5.sv
// Divide-by-1.5 clock generator, 33% duty, built from posedge/negedge flags; FREQ_DIV_LOCK_EN adds 'locked'.
// Latency: first out rise on the first rising clk with rst sampled low.
// Backpressure: none; free-running once out of reset.
module freq_div_1p5
    import freq_div_pkg::*;
(
    input  logic clk,
    input  logic rst,
`ifdef FREQ_DIV_LOCK_EN
    output logic locked,
`endif
    output logic out
);

    phase_t ph;
    phase_t ph_next;

    logic pos0;
    logic pos1;
    logic neg0;
    logic neg1;
    logic pos0_d;
    logic pos1_d;

    always_ff @(posedge clk) begin
        ph <= ph_next;
    end

    always_comb begin
        ph_next = PH_IDLE;
        pos0_d  = 1'b0;
        pos1_d  = 1'b0;
        if (!rst) begin
            ph_next = next_phase(ph);
        end
        pos0_d = (ph_next == PH_A);
        pos1_d = (ph_next == PH_B);
    end

    freq_div_edge_flag #(.NEG_EDGE(1'b0)) u_pos0 (
        .clk (clk),
        .rst (rst),
        .d   (pos0_d),
        .q   (pos0)
    );

    freq_div_edge_flag #(.NEG_EDGE(1'b0)) u_pos1 (
        .clk (clk),
        .rst (rst),
        .d   (pos1_d),
        .q   (pos1)
    );

    // Negedge copies delay each posedge flag by half a period to shape the pulse.
    freq_div_edge_flag #(.NEG_EDGE(1'b1)) u_neg0 (
        .clk (clk),
        .rst (rst),
        .d   (pos0),
        .q   (neg0)
    );

    freq_div_edge_flag #(.NEG_EDGE(1'b1)) u_neg1 (
        .clk (clk),
        .rst (rst),
        .d   (pos1),
        .q   (neg1)
    );

    // Each term changes only through one flag at a time, so no overlap glitches.
    assign out = (pos0 & ~neg0) | (pos1 & neg1);

`ifdef FREQ_DIV_LOCK_EN
    logic wrap_seen;
    logic wrap;

    assign wrap = (ph == PH_IDLE) && (ph_next == PH_A);

    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_seen <= 1'b0;
            locked    <= 1'b0;
        end else if (wrap) begin
            wrap_seen <= 1'b1;
            if (wrap_seen) begin
                locked <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_freq_div_1p5.sv
// Directed bench for freq_div_1p5: waveform, duty, reset hold, mid-pulse reset, optional lock.
module tb_freq_div_1p5;

    logic clk;
    logic rst;
    logic out;
`ifdef FREQ_DIV_LOCK_EN
    logic locked;
`endif

    int total = 0;
    int bad   = 0;
    int highs;

    logic chk_timing = 1'b0;
    logic have_prev  = 1'b0;
    time  rise_t     = 0;
    time  prev_rise  = 0;

    freq_div_1p5 dut (
        .clk    (clk),
        .rst    (rst),
`ifdef FREQ_DIV_LOCK_EN
        .locked (locked),
`endif
        .out    (out)
    );

    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s at t=%0t: observed=%0d expected=%0d", tag, $time, obs, exp);
        end
    endtask

    always @(posedge out) begin
        rise_t = $time;
        if (chk_timing) begin
            if (have_prev) begin
                total++;
                assert ((rise_t - prev_rise) === 60) else begin
                    bad++;
                    $error("FAIL spacing at t=%0t: observed=%0t expected=60", $time, rise_t - prev_rise);
                end
            end
            prev_rise = rise_t;
            have_prev = 1'b1;
        end
    end

    always @(negedge out) begin
        if (chk_timing) begin
            total++;
            assert (($time - rise_t) === 20) else begin
                bad++;
                $error("FAIL width at t=%0t: observed=%0t expected=20", $time, $time - rise_t);
            end
        end
    end

    initial begin
        rst = 1'b1;
        // Reset across falling edges at 40 and 80, release just after 80.
        #30;
        check("reset_out", {1'b0, out}, 2'd0);
        check("reset_ph", dut.ph, 2'd2);
        #51;
        rst = 1'b0;
        #9;
        check("pre_first_rise", {1'b0, out}, 2'd0);
        chk_timing = 1'b1;
        #20;
        // t=110: half-period samples, pulse pattern 1,0,0 repeating.
        highs = 0;
        for (int i = 0; i < 18; i++) begin
            check("wave", {1'b0, out}, (i % 3 == 0) ? 2'd1 : 2'd0);
            if (i < 6 && out === 1'b1) highs++;
`ifdef FREQ_DIV_LOCK_EN
            check("lock_rise", {1'b0, locked}, (i >= 6) ? 2'd1 : 2'd0);
`endif
            #20;
        end
        check("duty_120ns", highs[1:0], 2'd2);

        // t=470: assert reset after the falling edge, hold 10 cycles.
        #11;
        chk_timing = 1'b0;
        have_prev  = 1'b0;
        rst = 1'b1;
        #29;
        for (int i = 0; i < 20; i++) begin
            check("hold_out", {1'b0, out}, 2'd0);
            check("hold_ph", dut.ph, 2'd2);
`ifdef FREQ_DIV_LOCK_EN
            check("hold_lock", {1'b0, locked}, 2'd0);
`endif
            #20;
        end

        // t=910: release after the falling edge at 920; first pulse at 940.
        #11;
        rst = 1'b0;
        chk_timing = 1'b1;
        #29;
        for (int i = 0; i < 12; i++) begin
            check("wave2", {1'b0, out}, (i % 3 == 0) ? 2'd1 : 2'd0);
`ifdef FREQ_DIV_LOCK_EN
            check("lock2", {1'b0, locked}, (i >= 6) ? 2'd1 : 2'd0);
`endif
            #20;
        end

        // t=1190: one-cycle reset landing on the rising edge (1260) that ends the ph=1 pulse.
        #51;
        rst = 1'b1;
        #9;
        check("mid_pulse_live", {1'b0, out}, 2'd1);
        #11;
        rst = 1'b0;
        #9;
        check("mid_after_out", {1'b0, out}, 2'd0);
        check("mid_after_ph", dut.ph, 2'd2);
`ifdef FREQ_DIV_LOCK_EN
        check("mid_lock_clr", {1'b0, locked}, 2'd0);
`endif
        #20;
        check("mid_gap", {1'b0, out}, 2'd0);
        #20;
        // t=1310: restart from 1300.
        for (int i = 0; i < 12; i++) begin
            check("wave3", {1'b0, out}, (i % 3 == 0) ? 2'd1 : 2'd0);
`ifdef FREQ_DIV_LOCK_EN
            check("lock3", {1'b0, locked}, (i >= 6) ? 2'd1 : 2'd0);
`endif
            #20;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/freq_div_1p5.md
# freq_div_1p5

Clock divider producing an output at 2/3 of the input frequency (divide-by-1.5) with a 33.33% duty cycle. The output is high for exactly one input half-period out of every three. It uses both input clock edges and sits in the clock-generation area, driving a derived clock/strobe to downstream logic.

## Interface
- Parameters: none.
- `clk`  input  1  input clock; both edges used; duty cycle assumed 50%.
- `rst`  input  1  synchronous, active-high reset, sampled on rising `clk`.
- `out`  output  1  divided clock: period 1.5 × T(clk), high time 0.5 × T(clk).
- `locked`  output  1  present only with `FREQ_DIV_LOCK_EN`; see Configuration.

## Operation
- Phase counter `ph` (2 bits, values 0..2) advances on rising `clk`.
  - Reset value is 2. It runs 2→0→1→2→0… and never takes value 3.
  - The first rising edge with `rst`=0 moves `ph` to 0.
- Output waveform, repeating every 3 input cycles (6 half-periods):
  - `ph`=0: `out` high from the rising edge to the following falling edge.
  - `ph`=1: `out` low in the high half, high from the falling edge to the next rising edge.
  - `ph`=2: `out` low for the whole cycle.
- Implementation: registered flags only, no combinational gating of `clk`.
  - A posedge flag and a negedge flag for each pulse.
  - `out` = (pos0 & ~neg0) | (pos1 & neg1).
  - All flags are derived from `ph` so their overlap is glitch-free.
- Reset:
  - While `rst` is sampled high, all posedge flags clear and `ph`=2.
  - Negedge flags clear on any falling edge where `rst`=1.
  - `out`=0 from the first rising edge with `rst`=1 until the first pulse after release.
- Reset mid-operation: on the next rising edge `out` goes 0 and the phase restarts. No partial or stretched pulse is emitted after the reset edge.
- Before the first reset, `out` is undefined; the bench must apply reset first.

## Timing
- Latency: first `out` rising edge coincides with the first rising `clk` after `rst` is sampled low.
- Pulse width: exactly T/2.
- Spacing between consecutive `out` rising edges: exactly 1.5 T, alternating between a rising-edge-aligned and a falling-edge-aligned pulse.
- No glitches, including at the pulse boundary at the `ph`=1→2 rising edge.

## Configuration
- `FREQ_DIV_LOCK_EN` defined:
  - Adds output `locked`, reset to 0 synchronously.
  - `locked` goes 1 on the rising edge where `ph` wraps 2→0 for the second time after reset, i.e. after one full 3-cycle period.
  - It then stays 1 until the next reset.
- Not defined: no `locked` port and no associated logic.

## Structure
- Shared package `freq_div_pkg` holds:
  - phase typedef (2-bit) and constants `PH_A`=0, `PH_B`=1, `PH_IDLE`=2;
  - `DIV_CYCLES`=3.
- One sub-module is natural: `freq_div_edge_flag`, a single-bit flag register with synchronous reset, parameterised on clock edge and instantiated for the posedge and negedge flags.

## Test plan
- Clock T=40 ns. Reset asserted across two falling edges, released at t=80 → `out` rises at t=100, 0 at 120, 1 at 160, 0 at 180, 1 at 220, 0 at 240.
- Run 400 ns → every `out` high interval is 20 ns and consecutive rising edges are 60 ns apart; no glitch narrower than 20 ns.
- Hold `rst`=1 for 10 cycles → `out`=0 throughout. `ph` stays 2.
- Assert `rst` for one cycle during an `out` high half (`ph`=1 pulse) → `out` low from that rising edge. The first pulse restarts one cycle after release.
- With `FREQ_DIV_LOCK_EN`, after release at t=80 → `locked`=0 until the rising edge at t=220, then 1; re-asserting `rst` clears it on the next rising edge.
- Duty check over 3 input periods (120 ns) → `out` high for exactly 40 ns total (33.33%).
